// File: rtl/adsr_envelope_sequencer.sv
// Per-voice ADSR envelope controller.
// Sequences IDLE -> ATTACK -> DECAY -> SUSTAIN -> RELEASE on keyboard gate
// edges, stepping the gain word once per sample tick. Gate edges are handled
// on every clock. An edge that coincides with a tick takes priority, and the
// envelope is not stepped on that cycle.
module adsr_envelope_sequencer #(
    parameter int ENV_W = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             gate,
    input  logic [3:0]       note,
    input  logic [2:0]       octave,
    input  logic [ENV_W-1:0] amplitude,
    input  logic [ENV_W-1:0] attack,
    input  logic [ENV_W-1:0] decay,
    input  logic [ENV_W-1:0] sustain,
    input  logic [ENV_W-1:0] rel,
    output logic [ENV_W-1:0] env,
    output logic [2:0]       env_state,
    output logic             active,
    output logic [3:0]       note_out,
    output logic [2:0]       octave_out,
    output logic             note_on_pulse
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_DECAY   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic             gate_q;
    logic [2:0]       state_q, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic [3:0]       note_q, note_d;
    logic [2:0]       oct_q, oct_d;
    logic             pulse_q;

    logic             rise, fall;
    logic [ENV_W-1:0] tgt;
    logic [ENV_W:0]   att_sum;
    logic [ENV_W:0]   dec_lim;

    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;

    // Sustain target and widened sums; the extra bit keeps the comparisons free of wrap-around
    always_comb begin
        tgt     = (sustain < amplitude) ? sustain : amplitude;
        att_sum = {1'b0, env_q} + {1'b0, attack};
        dec_lim = {1'b0, tgt} + {1'b0, decay};
    end

    // Next-state and envelope step; gate edges pre-empt the tick step
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (rise) begin
            // Retrigger keeps the current level so the attack starts without a click
            state_d = S_ATTACK;
        end else if (fall) begin
            if (state_q == S_ATTACK || state_q == S_DECAY || state_q == S_SUSTAIN) begin
                state_d = S_RELEASE;
            end
        end else if (tick) begin
            case (state_q)
                S_ATTACK: begin
                    // Also clamps when amplitude has been lowered below the current level
                    if (att_sum >= {1'b0, amplitude}) begin
                        env_d   = amplitude;
                        state_d = S_DECAY;
                    end else begin
                        env_d = att_sum[ENV_W-1:0];
                    end
                end
                S_DECAY: begin
                    if (decay == '0) begin
                        state_d = S_SUSTAIN;
                    end else if ({1'b0, env_q} <= dec_lim) begin
                        env_d   = tgt;
                        state_d = S_SUSTAIN;
                    end else begin
                        env_d = env_q - decay;
                    end
                end
                S_SUSTAIN: begin
                    env_d = env_q;
                end
                S_RELEASE: begin
                    if (env_q <= rel) begin
                        env_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        env_d = env_q - rel;
                    end
                end
                default: begin
                    env_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Note/octave latch: on a trigger, and while the key stays held so legato re-pitches
    always_comb begin
        note_d = note_q;
        oct_d  = oct_q;
        if (rise || (gate && gate_q)) begin
            note_d = note;
            oct_d  = octave;
        end
    end

    // State registers; reset aborts any envelope in progress immediately
    always_ff @(posedge clk) begin
        if (!reset) begin
            gate_q  <= 1'b0;
            state_q <= S_IDLE;
            env_q   <= '0;
            note_q  <= 4'd0;
            oct_q   <= 3'd4;
            pulse_q <= 1'b0;
        end else begin
            gate_q  <= gate;
            state_q <= state_d;
            env_q   <= env_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
            pulse_q <= rise;
        end
    end

    assign env           = env_q;
    assign env_state     = state_q;
    assign active        = (state_q != S_IDLE);
    assign note_out      = note_q;
    assign octave_out    = oct_q;
    assign note_on_pulse = pulse_q;

endmodule

// File: doc/adsr_envelope_sequencer.md
Name: adsr_envelope_sequencer

Overview:
Per-voice envelope controller that sequences the synth amplitude path through IDLE/ATTACK/DECAY/SUSTAIN/RELEASE.
- Driven by the keyboard gate (note_in) and the live octave/amplitude/ADSR registers.
- Advances once per audio sample tick.
- Its env output is the gain word the waveform ALU multiplies into wave_out.
- It also latches the note and octave so the oscillator keeps its pitch during release.

Parameters:
ENV_W, 31, width of env, amplitude and all ADSR rate/level inputs.

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-low reset
tick  in  1  one-clk sample strobe (48 kHz); envelope arithmetic only on tick cycles
gate  in  1  key held (note_in from PS2 decoder)
note  in  4  current key note index
octave  in  3  current octave register
amplitude  in  ENV_W  peak level
attack  in  ENV_W  per-tick increment in ATTACK
decay  in  ENV_W  per-tick decrement in DECAY; 0 = no decay
sustain  in  ENV_W  sustain level
rel  in  ENV_W  per-tick decrement in RELEASE
env  out  ENV_W  current envelope level
env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
active  out  1  high when env_state != IDLE
note_out  out  4  latched note
octave_out  out  3  latched octave
note_on_pulse  out  1  one-clk pulse on each (re)trigger

Behaviour:
Reset (reset==0 at posedge clk):
- env=0, env_state=IDLE, active=0, note_out=0, octave_out=4, note_on_pulse=0, gate_q=0.
- Reset mid-envelope aborts immediately; env drops to 0.

Gate edges:
- gate registered every clk into gate_q. rise = gate & ~gate_q; fall = ~gate & gate_q.
- Edges are processed on every clk, not only on tick.
- rise, any state: next env_state=ATTACK; latch note/octave; note_on_pulse=1 for that one cycle.
- env keeps its current value on retrigger. It does not reset to 0 (no click).
- fall in ATTACK/DECAY/SUSTAIN: next env_state=RELEASE; env unchanged.
- fall in IDLE/RELEASE: no effect.
- Edge transition on the same cycle as tick: the transition wins and env is not stepped that cycle.
- gate high and note changes without a rise (legato): note_out/octave_out re-latch; envelope not restarted.

Envelope arithmetic (tick==1, no edge that cycle):
- All math in ENV_W+1 bits; no wrap-around.
- Sustain target: tgt = min(sustain, amplitude).
- ATTACK: s = env + attack.
  - If s >= amplitude: env=amplitude, go to DECAY.
  - Else env=s.
  - attack >= amplitude reaches peak in 1 tick.
- DECAY:
  - If decay==0: go to SUSTAIN, env unchanged.
  - Else if env <= tgt + decay: env=tgt, go to SUSTAIN.
  - Else env = env - decay.
- SUSTAIN: env held constant; gate fall is the only exit.
- RELEASE:
  - If env <= rel: env=0, go to IDLE.
  - Else env = env - rel.
  - rel==0 holds env until the next rise or reset.
- IDLE: env=0.

Other rules:
- If amplitude drops below env during ATTACK, the next tick clamps env to amplitude and enters DECAY.
- Outputs are registered. env and env_state change on the clk edge after the qualifying tick/edge.

Test Plan:
- Reset: assert reset=0 with gate=1 mid-ATTACK -> next cycle env=0, env_state=0, octave_out=4, active=0.
- Attack/decay: amplitude=1073741824, attack=268435456, decay=134217728, sustain=805306368, gate rise then ticks.
  - env after ticks 1-4: 268435456, 536870912, 805306368, 1073741824 (DECAY entered).
  - Then 939524096, then 805306368 with SUSTAIN entered.
- Defaults: attack=amplitude=sustain=rel=1073741824, decay=0, gate rise.
  - Tick1: env=1073741824, DECAY. Tick2: SUSTAIN.
  - Gate fall, tick: env=0, IDLE.
- Release clamp: env=1073741824 in SUSTAIN, rel=400000000, gate fall.
  - Env after ticks: 673741824, then 273741824, then 0 with IDLE.
- Retrigger: gate fall then rise during RELEASE at env=673741824, with rise coincident with tick.
  - env_state=ATTACK, env stays 673741824 that cycle, note_on_pulse=1 for one clk, note_out updated.
- Legato: gate held in SUSTAIN, note 3->7, octave 4->5.
  - note_out=7, octave_out=5, env_state stays 3, no note_on_pulse.
